// File: rtl/hyperram_tester_pkg.sv
// Shared types and constants for the HyperRAM AXI traffic generator/checker.
// Holds the FSM state enum, AXI encodings and the LFSR step function.
package hyperram_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WA,
        ST_WD,
        ST_WB,
        ST_RA,
        ST_RD,
        ST_FIN
    } state_t;

    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;

    // Right-shifting Galois step for x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/hyperram_axi_tester_if.sv
// AXI4 write/read channel bundle between the tester (master) and the HyperRAM controller (slave).
interface hyperram_axi_tester_if;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/hyperram_lfsr32.sv
// 32-bit Galois LFSR pattern generator: load has priority over advance.
module hyperram_lfsr32
    import hyperram_tester_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/hyperram_axi_tester.sv
// AXI4 burst write/readback tester for the HyperRAM controller.
// Define HYPR_TESTER_ERRCAPTURE_EN to add first-mismatch capture ports err_addr/err_exp/err_act.
module hyperram_axi_tester
    import hyperram_tester_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    hyperram_axi_tester_if.master m_axi,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_bursts,
    input  logic [31:0]          seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     err_count
`ifdef HYPR_TESTER_ERRCAPTURE_EN
    ,
    output logic [31:0]          err_addr,
    output logic [31:0]          err_exp,
    output logic [31:0]          err_act
`endif
);

    localparam logic [31:0]      STRIDE    = 32'(BURST_LEN * 4);
    localparam logic [8:0]       LAST_BEAT = 9'(BURST_LEN - 1);
    localparam logic [7:0]       AXLEN     = 8'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] nb_r;
    logic [CNT_W-1:0] burst_idx;
    logic [31:0]      seed_r;
    logic [31:0]      addr;
    logic [8:0]       beat;
    logic             awvalid_r, wvalid_r, wlast_r, bready_r, arvalid_r, rready_r;
`ifdef HYPR_TESTER_ERRCAPTURE_EN
    logic             err_seen;
`endif

    logic [31:0] lfsr_val;
    logic [31:0] seed_fix;
    logic [31:0] lfsr_seed;
    logic        lfsr_load;
    logic        lfsr_adv;
    logic        w_hs;
    logic        r_hs;
    logic        last_burst;
    logic        data_bad;
    logic        resp_bad;
    logic        last_bad;
    logic [1:0]  rd_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    assign seed_fix   = (seed == 32'h0) ? 32'h1 : seed;
    assign w_hs       = wvalid_r & m_axi.wready;
    assign r_hs       = rready_r & m_axi.rvalid;
    assign last_burst = (burst_idx == nb_r - ONE);

    // Reload on the last write response so burst 0 of the read phase replays the write pattern
    assign lfsr_load = ((state == ST_IDLE) && start)
                     || ((state == ST_WB) && m_axi.bvalid && last_burst);
    assign lfsr_seed = (state == ST_IDLE) ? seed_fix : seed_r;
    assign lfsr_adv  = w_hs | r_hs;

    assign data_bad = (m_axi.rdata != lfsr_val);
    assign resp_bad = (m_axi.rresp != AXI_RESP_OKAY);
    assign last_bad = (m_axi.rlast != (beat == LAST_BEAT));
    assign rd_inc   = {1'b0, data_bad | resp_bad} + {1'b0, last_bad};

    hyperram_lfsr32 u_lfsr (
        .clk     (s_axi_aclk),
        .rst_n   (s_axi_aresetn),
        .load    (lfsr_load),
        .seed    (lfsr_seed),
        .advance (lfsr_adv),
        .value   (lfsr_val)
    );

    // Payloads are gated by their valid so every output reads 0 in reset and between transfers
    assign m_axi.awaddr  = awvalid_r ? addr           : '0;
    assign m_axi.awlen   = awvalid_r ? AXLEN          : '0;
    assign m_axi.awsize  = awvalid_r ? AXI_SIZE_4B    : '0;
    assign m_axi.awburst = awvalid_r ? AXI_BURST_INCR : '0;
    assign m_axi.awvalid = awvalid_r;
    assign m_axi.wdata   = wvalid_r  ? lfsr_val       : '0;
    assign m_axi.wstrb   = wvalid_r  ? 4'hF           : '0;
    assign m_axi.wlast   = wlast_r;
    assign m_axi.wvalid  = wvalid_r;
    assign m_axi.bready  = bready_r;
    assign m_axi.araddr  = arvalid_r ? addr           : '0;
    assign m_axi.arlen   = arvalid_r ? AXLEN          : '0;
    assign m_axi.arsize  = arvalid_r ? AXI_SIZE_4B    : '0;
    assign m_axi.arburst = arvalid_r ? AXI_BURST_INCR : '0;
    assign m_axi.arvalid = arvalid_r;
    assign m_axi.rready  = rready_r;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state     <= ST_IDLE;
            nb_r      <= '0;
            burst_idx <= '0;
            seed_r    <= '0;
            addr      <= '0;
            beat      <= '0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            wlast_r   <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
`ifdef HYPR_TESTER_ERRCAPTURE_EN
            err_seen  <= 1'b0;
            err_addr  <= '0;
            err_exp   <= '0;
            err_act   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        nb_r      <= num_bursts;
                        seed_r    <= seed_fix;
                        burst_idx <= '0;
                        addr      <= BASE_ADDR;
                        beat      <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
`ifdef HYPR_TESTER_ERRCAPTURE_EN
                        err_seen  <= 1'b0;
                        err_addr  <= '0;
                        err_exp   <= '0;
                        err_act   <= '0;
`endif
                        if (num_bursts == '0) begin
                            state <= ST_FIN;
                        end else begin
                            awvalid_r <= 1'b1;
                            state     <= ST_WA;
                        end
                    end
                end

                ST_WA: begin
                    if (m_axi.awready) begin
                        awvalid_r <= 1'b0;
                        wvalid_r  <= 1'b1;
                        beat      <= '0;
                        wlast_r   <= (LAST_BEAT == 9'd0);
                        state     <= ST_WD;
                    end
                end

                ST_WD: begin
                    if (m_axi.wready) begin
                        if (wlast_r) begin
                            wvalid_r <= 1'b0;
                            wlast_r  <= 1'b0;
                            bready_r <= 1'b1;
                            state    <= ST_WB;
                        end else begin
                            beat    <= beat + 9'd1;
                            wlast_r <= (beat + 9'd1 == LAST_BEAT);
                        end
                    end
                end

                ST_WB: begin
                    if (m_axi.bvalid) begin
                        bready_r <= 1'b0;
                        if (m_axi.bresp != AXI_RESP_OKAY) begin
                            err_count <= sat_add(err_count, 2'd1);
                        end
                        if (last_burst) begin
                            burst_idx <= '0;
                            addr      <= BASE_ADDR;
                            arvalid_r <= 1'b1;
                            state     <= ST_RA;
                        end else begin
                            burst_idx <= burst_idx + ONE;
                            addr      <= addr + STRIDE;
                            awvalid_r <= 1'b1;
                            state     <= ST_WA;
                        end
                    end
                end

                ST_RA: begin
                    if (m_axi.arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        beat      <= '0;
                        state     <= ST_RD;
                    end
                end

                ST_RD: begin
                    if (m_axi.rvalid) begin
                        err_count <= sat_add(err_count, rd_inc);
`ifdef HYPR_TESTER_ERRCAPTURE_EN
                        if (data_bad && !err_seen) begin
                            err_seen <= 1'b1;
                            err_addr <= addr + (32'(beat) << 2);
                            err_exp  <= lfsr_val;
                            err_act  <= m_axi.rdata;
                        end
`endif
                        if (beat == LAST_BEAT) begin
                            rready_r <= 1'b0;
                            beat     <= '0;
                            if (last_burst) begin
                                state <= ST_FIN;
                            end else begin
                                burst_idx <= burst_idx + ONE;
                                addr      <= addr + STRIDE;
                                arvalid_r <= 1'b1;
                                state     <= ST_RA;
                            end
                        end else begin
                            beat <= beat + 9'd1;
                        end
                    end
                end

                ST_FIN: begin
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperram_axi_tester.sv
// Directed bench for hyperram_axi_tester with a behavioural AXI slave memory.
module tb_hyperram_axi_tester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_bursts;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [15:0] err_count;
`ifdef HYPR_TESTER_ERRCAPTURE_EN
    logic [31:0] err_addr, err_exp, err_act;
`endif

    always #5 clk = ~clk;

    hyperram_axi_tester_if axi();

    hyperram_axi_tester #(
        .BASE_ADDR (32'h0),
        .BURST_LEN (16),
        .CNT_W     (16)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .m_axi         (axi),
        .start         (start),
        .num_bursts    (num_bursts),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count)
`ifdef HYPR_TESTER_ERRCAPTURE_EN
        ,
        .err_addr      (err_addr),
        .err_exp       (err_exp),
        .err_act       (err_act)
`endif
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // slave model state
    logic [31:0] mem [0:255];
    logic [31:0] wlog [0:2];
    bit          stall_en, bresp_err_en, corrupt_en;
    bit          r_active, b_pend, any_valid;
    int          cur_waddr_w, cur_raddr_w, wbeat, rbeat;
    int          w_beats, r_beats, stab_err;
    bit          aw_wait, w_wait, ar_wait;
    logic [31:0] prev_awaddr, prev_wdata, prev_araddr;

    function automatic bit coin();
        return stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        w_beats   = 0;
        r_beats   = 0;
        stab_err  = 0;
        any_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 32'({busy, done, pass, axi.awvalid, axi.wvalid, axi.wlast,
                                  axi.bready, axi.arvalid, axi.rready}), 32'h0);
        check({tag, "_err"}, 32'(err_count), 32'h0);
        check({tag, "_data"}, axi.wdata | axi.awaddr | axi.araddr, 32'h0);
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 20000 && !done; i++) @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'h1);
    endtask

    task automatic launch(input string tag, input logic [15:0] nb, input logic [31:0] sd);
        clear_stats();
        @(negedge clk);
        start      = 1'b1;
        num_bursts = nb;
        seed       = sd;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'h1);
        check({tag, "_done_clr"}, 32'(done), 32'h0);
    endtask

    // Behavioural slave: decides ready/valid at each negedge; a decision made here completes at the next posedge
    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid  = 1'b0; axi.bresp  = 2'b00;
        axi.rvalid  = 1'b0; axi.rdata  = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
        r_active = 1'b0; b_pend = 1'b0; aw_wait = 1'b0; w_wait = 1'b0; ar_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
                axi.bvalid  = 1'b0; axi.rvalid = 1'b0; axi.rlast  = 1'b0;
                r_active = 1'b0; b_pend = 1'b0;
                aw_wait = 1'b0; w_wait = 1'b0; ar_wait = 1'b0;
            end else begin
                if (axi.awvalid || axi.wvalid || axi.arvalid) any_valid = 1'b1;
                if (aw_wait && axi.awvalid && axi.awaddr != prev_awaddr) stab_err++;
                if (w_wait  && axi.wvalid  && axi.wdata  != prev_wdata)  stab_err++;
                if (ar_wait && axi.arvalid && axi.araddr != prev_araddr) stab_err++;

                if (axi.bvalid) axi.bvalid = 1'b0;
                if (b_pend) begin
                    axi.bvalid = 1'b1;
                    axi.bresp  = bresp_err_en ? 2'b10 : 2'b00;
                    b_pend     = 1'b0;
                end

                if (axi.rvalid) begin
                    r_beats++;
                    rbeat++;
                    if (rbeat == 16) r_active = 1'b0;
                end
                axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0;
                if (r_active && coin()) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = mem[cur_raddr_w + rbeat];
                    if (corrupt_en && cur_raddr_w == 32 && rbeat == 3) axi.rdata = axi.rdata ^ 32'h1;
                    axi.rlast  = (rbeat == 15);
                    axi.rresp  = 2'b00;
                end

                axi.arready = axi.arvalid && coin();
                if (axi.arready) begin
                    cur_raddr_w = int'(axi.araddr[9:2]);
                    rbeat       = 0;
                    r_active    = 1'b1;
                end

                axi.awready = axi.awvalid && coin();
                if (axi.awready) begin
                    cur_waddr_w = int'(axi.awaddr[9:2]);
                    wbeat       = 0;
                end

                axi.wready = axi.wvalid && coin();
                if (axi.wready) begin
                    mem[cur_waddr_w + wbeat] = axi.wdata;
                    if (w_beats < 3) wlog[w_beats] = axi.wdata;
                    w_beats++;
                    wbeat++;
                    if (axi.wlast) b_pend = 1'b1;
                end

                aw_wait = axi.awvalid && !axi.awready; prev_awaddr = axi.awaddr;
                w_wait  = axi.wvalid  && !axi.wready;  prev_wdata  = axi.wdata;
                ar_wait = axi.arvalid && !axi.arready; prev_araddr = axi.araddr;
            end
        end
    end

    initial begin
        int i;
        rst_n = 1'b0; start = 1'b0; num_bursts = '0; seed = '0;
        stall_en = 1'b0; bresp_err_en = 1'b0; corrupt_en = 1'b0;
        clear_stats();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Reset during write burst 0, around beat 5
        launch("s1", 16'd4, 32'h5);
        for (i = 0; i < 200 && !(axi.wvalid && w_beats >= 5); i++) @(negedge clk);
        check("s1_reach_wd", 32'(w_beats), 32'd5);
        #2 rst_n = 1'b0;
        #1 check_all_zero("s1_async");
        @(negedge clk);
        check_all_zero("s1_next");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        launch("s1b", 16'd2, 32'h1);
        wait_done("s1b");
        check("s1b_pass", 32'(pass), 32'h1);
        check("s1b_err", 32'(err_count), 32'h0);
        check("s1b_wbeats", 32'(w_beats), 32'd32);
        check("s1b_rbeats", 32'(r_beats), 32'd32);

        // Ideal slave, seed 1, four bursts
        launch("s2", 16'd4, 32'h1);
        wait_done("s2");
        check("s2_pass", 32'(pass), 32'h1);
        check("s2_err", 32'(err_count), 32'h0);
        check("s2_wbeats", 32'(w_beats), 32'd64);
        check("s2_rbeats", 32'(r_beats), 32'd64);
        check("s2_wdata0", wlog[0], 32'h0000_0001);
        check("s2_wdata1", wlog[1], 32'h8020_0003);
        check("s2_wdata2", wlog[2], 32'hC030_0002);

        // Corrupted read beat: burst 2, beat 3
        corrupt_en = 1'b1;
        launch("s3", 16'd4, 32'h1);
        wait_done("s3");
        corrupt_en = 1'b0;
        check("s3_err", 32'(err_count), 32'h1);
        check("s3_pass", 32'(pass), 32'h0);
`ifdef HYPR_TESTER_ERRCAPTURE_EN
        check("s3_err_addr", err_addr, 32'h8C);
        check("s3_err_exp", err_exp, mem[35]);
        check("s3_err_act", err_act, mem[35] ^ 32'h1);
`endif

        // Random handshake stalls
        stall_en = 1'b1;
        launch("s4", 16'd4, 32'h1);
        wait_done("s4");
        stall_en = 1'b0;
        check("s4_pass", 32'(pass), 32'h1);
        check("s4_err", 32'(err_count), 32'h0);
        check("s4_stable", 32'(stab_err), 32'h0);
        check("s4_wbeats", 32'(w_beats), 32'd64);
        check("s4_rbeats", 32'(r_beats), 32'd64);
        check("s4_wdata1", wlog[1], 32'h8020_0003);

        // Zero bursts, plus a start pulse during FIN that must be ignored
        clear_stats();
        @(negedge clk);
        start = 1'b1; num_bursts = 16'd0; seed = 32'h0;
        @(negedge clk);
        check("s5_busy", 32'(busy), 32'h1);
        check("s5_done_early", 32'(done), 32'h0);
        start = 1'b1; num_bursts = 16'd4;
        @(negedge clk);
        start = 1'b0;
        check("s5_done", 32'(done), 32'h1);
        check("s5_pass", 32'(pass), 32'h1);
        check("s5_busy_clr", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);
        check("s5_still_idle", 32'(busy), 32'h0);
        check("s5_no_valid", 32'(any_valid), 32'h0);
        check("s5_done_held", 32'(done), 32'h1);

        // Every write response is SLVERR
        bresp_err_en = 1'b1;
        launch("s6", 16'd3, 32'hABCD_1234);
        wait_done("s6");
        bresp_err_en = 1'b0;
        check("s6_err", 32'(err_count), 32'd3);
        check("s6_pass", 32'(pass), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
